bpu_update: RTL and testbench
=============================

Name: bpu_update

Overview:
- Write side of the branch predictor; pairs with the fetch-side next-PC selector.
- Takes branch resolutions from execute and detects mispredicts. On a mispredict it drives a one-cycle redirect to fetch.
- Queues BTB/direction-counter update requests in a small FIFO and drains them to the BTB write port with a valid/ready handshake.
- Keeps saturating performance counters.

Parameters:
- DEPTH, 4, update FIFO entries (power of two, ≥2)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ex_valid  in  1  resolved instruction present this cycle
- ex_pc  in  64  PC of resolved instruction
- ex_type  in  3  actual type: 000 none, 001 B_CON, 010 JAL, 011 JALR, 100 CALL, 101 RET, 110 CALL_RET
- ex_taken  in  1  actual direction (1 for all jump types)
- ex_target  in  64  actual target
- ex_pred_hit  in  1  BTB hit carried with the instruction
- ex_pred_npc  in  64  next PC fetch actually used after this instruction
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  64  correct next PC
- wr_valid  out  1  BTB update request valid (FIFO head)
- wr_ready  in  1  BTB accepts request
- wr_pc  out  64  entry index/tag PC
- wr_type  out  3  type to store; 000 invalidates the entry
- wr_target  out  64  target to store
- wr_taken  out  1  counter direction (increment if 1, decrement if 0)
- br_cnt  out  CNT_W  resolved branches (ex_type≠0)
- mp_cnt  out  CNT_W  mispredicts
- drop_cnt  out  16  updates dropped because the FIFO was full

Behaviour:
- Reset (async, rstn=0): every output is 0. FIFO is emptied and its pointers are 0. Deassertion takes effect on the next clk edge. Reset mid-drain discards all queued entries.
- pc4 = ex_pc + 64'd4 (mod 2^64).
- actual_npc:
  - ex_taken=1 and ex_type≠0: ex_target
  - otherwise: pc4
- Accepted resolution: ex_valid=1 and redirect_valid=0. In the cycle redirect_valid=1 (shadow cycle), ex_valid is ignored entirely.
- Mispredict: an accepted resolution with ex_pred_npc ≠ actual_npc.
- Redirect registered, latency 1: on the edge after a mispredict, redirect_valid=1 and redirect_pc=actual_npc for exactly one cycle.
- Update needed for an accepted resolution:
  - ex_type≠0: write {ex_pc, ex_type, ex_target, ex_taken}.
  - ex_type=0 with ex_pred_hit=1 (false hit): write {ex_pc, 000, 0, 0}, which invalidates the entry.
  - ex_type=0 with ex_pred_hit=0: no update.
- FIFO:
  - Push on update needed.
  - Pop when wr_valid & wr_ready.
  - wr_* always reflect the head entry, which holds stable while wr_valid=1 and wr_ready=0.
  - No bypass: a pushed entry first appears on wr_valid the cycle after ex_valid.
  - Full, no pop: the push is dropped, drop_cnt increments (saturating at 16'hFFFF), and the redirect is still issued.
  - Full with simultaneous pop: the push is accepted.
  - Empty with simultaneous push: wr_valid rises next cycle.
  - Pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits distinguishes full from empty.
- Counters, registered (value visible the cycle after the event), saturating at all ones, never wrapping:
  - br_cnt +1 per accepted resolution with ex_type≠0.
  - mp_cnt +1 per mispredict.

Test Plan:
- B_CON predicted not-taken, actually taken: ex_pc=0x1000, ex_target=0x2000, ex_taken=1, ex_pred_npc=0x1004.
  → next cycle redirect_valid=1, redirect_pc=0x2000; mp_cnt=1, br_cnt=1.
  → wr_valid=1 with wr_pc=0x1000, wr_type=001, wr_target=0x2000, wr_taken=1.
- Correct JAL: ex_pred_npc = ex_target = 0x3000.
  → no redirect; an update is still queued; mp_cnt unchanged.
- False hit: ex_type=0, ex_pred_hit=1, ex_pc=0x40, ex_pred_npc=0x80.
  → redirect_pc=0x44; update wr_type=000.
- Shadow: two mispredicts back to back.
  → only the first redirects; the second is ignored (br_cnt +1 only).
- Back-pressure: hold wr_ready=0 and issue DEPTH+2 updates.
  → DEPTH entries kept in order, drop_cnt=2, head stable.
  → then raise wr_ready: entries drain one per cycle in order, and wr_valid falls after the last.
- Reset asserted with 3 queued entries and redirect_valid high.
  → all outputs 0 immediately (asynchronously); after release wr_valid stays 0 until a new update.

Source files
------------

// File: rtl/bpu_update.sv
// Branch predictor write side: resolves branches from execute, issues mispredict redirects,
// queues BTB/direction-counter updates in a small FIFO and keeps saturating perf counters.
module bpu_update #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ex_valid,
    input  logic [63:0]      ex_pc,
    input  logic [2:0]       ex_type,
    input  logic             ex_taken,
    input  logic [63:0]      ex_target,
    input  logic             ex_pred_hit,
    input  logic [63:0]      ex_pred_npc,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [63:0]      wr_pc,
    output logic [2:0]       wr_type,
    output logic [63:0]      wr_target,
    output logic             wr_taken,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned DROP_W = 16;

    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  typ;
        logic [63:0] target;
        logic        taken;
    } upd_t;

    upd_t              mem_q [DEPTH];
    upd_t              mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [63:0]       redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        accept_c;
    logic        is_branch_c;
    logic [63:0] actual_npc_c;
    logic        mispredict_c;
    logic        need_upd_c;
    logic        full_c;
    logic        pop_c;
    logic        push_c;
    logic        drop_c;
    upd_t        new_entry_c;

    // Resolution decode; the cycle carrying a redirect is a shadow and ignores ex_valid.
    always_comb begin
        accept_c     = ex_valid && !redirect_valid_q;
        is_branch_c  = (ex_type != 3'b000);
        actual_npc_c = (ex_taken && is_branch_c) ? ex_target : (ex_pc + 64'd4);
        mispredict_c = accept_c && (ex_pred_npc != actual_npc_c);
        need_upd_c   = accept_c && (is_branch_c || ex_pred_hit);

        new_entry_c = '0;
        if (is_branch_c) begin
            new_entry_c.pc     = ex_pc;
            new_entry_c.typ    = ex_type;
            new_entry_c.target = ex_target;
            new_entry_c.taken  = ex_taken;
        end else begin
            new_entry_c.pc = ex_pc;
        end
    end

    // FIFO control: a full queue still accepts a push when the head drains the same cycle.
    always_comb begin
        full_c = (count_q == FCNT_W'(DEPTH));
        pop_c  = (count_q != '0) && wr_ready;
        push_c = need_upd_c && (!full_c || pop_c);
        drop_c = need_upd_c && full_c && !pop_c;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = new_entry_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
    end

    // Redirect pulse and saturating performance counters.
    always_comb begin
        redirect_valid_d = mispredict_c;
        redirect_pc_d    = mispredict_c ? actual_npc_c : redirect_pc_q;

        br_cnt_d   = br_cnt_q;
        mp_cnt_d   = mp_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (accept_c && is_branch_c && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mispredict_c && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + CNT_W'(1);
        end
        if (drop_c && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_cnt_q         <= '0;
            mp_cnt_q         <= '0;
            drop_cnt_q       <= '0;
        end else begin
            mem_q            <= mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_cnt_q         <= br_cnt_d;
            mp_cnt_q         <= mp_cnt_d;
            drop_cnt_q       <= drop_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign wr_valid       = (count_q != '0);
    assign wr_pc          = mem_q[rd_ptr_q].pc;
    assign wr_type        = mem_q[rd_ptr_q].typ;
    assign wr_target      = mem_q[rd_ptr_q].target;
    assign wr_taken       = mem_q[rd_ptr_q].taken;
    assign br_cnt         = br_cnt_q;
    assign mp_cnt         = mp_cnt_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_bpu_update.sv
// Bench for bpu_update: directed test-plan steps plus randomized traffic against a queue-based model.
module tb_bpu_update;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rstn;
    logic             ex_valid;
    logic [63:0]      ex_pc;
    logic [2:0]       ex_type;
    logic             ex_taken;
    logic [63:0]      ex_target;
    logic             ex_pred_hit;
    logic [63:0]      ex_pred_npc;
    logic             redirect_valid;
    logic [63:0]      redirect_pc;
    logic             wr_valid;
    logic             wr_ready;
    logic [63:0]      wr_pc;
    logic [2:0]       wr_type;
    logic [63:0]      wr_target;
    logic             wr_taken;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;
    logic [15:0]      drop_cnt;

    bpu_update #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_type(ex_type), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_hit(ex_pred_hit), .ex_pred_npc(ex_pred_npc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pc(wr_pc), .wr_type(wr_type),
        .wr_target(wr_target), .wr_taken(wr_taken),
        .br_cnt(br_cnt), .mp_cnt(mp_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  typ;
        logic [63:0] target;
        logic        taken;
    } ent_t;

    ent_t        mq[$];
    logic        m_rv;
    logic [63:0] m_rpc;
    longint      m_br, m_mp, m_drop;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        chk("wr_valid", 64'(wr_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("wr_pc", wr_pc, mq[0].pc);
            chk("wr_type", 64'(wr_type), 64'(mq[0].typ));
            chk("wr_target", wr_target, mq[0].target);
            chk("wr_taken", 64'(wr_taken), 64'(mq[0].taken));
        end
        chk("br_cnt", 64'(br_cnt), 64'(m_br));
        chk("mp_cnt", 64'(mp_cnt), 64'(m_mp));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic model_reset();
        mq.delete();
        m_rv = 1'b0; m_rpc = '0;
        m_br = 0; m_mp = 0; m_drop = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then compare after the edge.
    task automatic step();
        logic        acc, mis, need;
        logic [63:0] anpc;
        ent_t        e;
        acc  = ex_valid && !m_rv;
        anpc = (ex_taken && ex_type != 3'b000) ? ex_target : ex_pc + 64'd4;
        mis  = acc && (ex_pred_npc != anpc);
        need = acc && (ex_type != 3'b000 || ex_pred_hit);
        if (mq.size() != 0 && wr_ready) e = mq.pop_front();
        if (need) begin
            if (ex_type != 3'b000) begin
                e.pc = ex_pc; e.typ = ex_type; e.target = ex_target; e.taken = ex_taken;
            end else begin
                e.pc = ex_pc; e.typ = 3'b000; e.target = '0; e.taken = 1'b0;
            end
            if (mq.size() < DEPTH) mq.push_back(e);
            else if (m_drop < 65535) m_drop++;
        end
        if (acc && ex_type != 3'b000) m_br++;
        if (mis) begin m_mp++; m_rpc = anpc; end
        m_rv = mis;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [2:0] typ,
                         input logic tk, input logic [63:0] tgt, input logic hit,
                         input logic [63:0] pnpc);
        ex_valid = v; ex_pc = pc; ex_type = typ; ex_taken = tk;
        ex_target = tgt; ex_pred_hit = hit; ex_pred_npc = pnpc;
    endtask

    task automatic idle();
        drive(1'b0, '0, 3'b000, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [63:0] pc, tgt, pn;
        logic [2:0]  ty;
        logic        tk;
        longint      br_before;
        int          guard;
        checks = 0; failures = 0;
        rstn = 1'b0; wr_ready = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_br_cnt", 64'(br_cnt), 64'd0);
        rstn = 1'b1;
        step();

        // B_CON predicted not-taken, actually taken
        drive(1'b1, 64'h1000, 3'b001, 1'b1, 64'h2000, 1'b0, 64'h1004);
        step();
        chk("bcon_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("bcon_redirect_pc", redirect_pc, 64'h2000);
        chk("bcon_mp_cnt", 64'(mp_cnt), 64'd1);
        chk("bcon_br_cnt", 64'(br_cnt), 64'd1);
        chk("bcon_wr_valid", 64'(wr_valid), 64'd1);
        chk("bcon_wr_pc", wr_pc, 64'h1000);
        chk("bcon_wr_type", 64'(wr_type), 64'd1);
        chk("bcon_wr_target", wr_target, 64'h2000);
        chk("bcon_wr_taken", 64'(wr_taken), 64'd1);
        idle();
        step();

        // Correctly predicted JAL
        drive(1'b1, 64'h2ff0, 3'b010, 1'b1, 64'h3000, 1'b1, 64'h3000);
        step();
        chk("jal_no_redirect", 64'(redirect_valid), 64'd0);
        chk("jal_mp_cnt", 64'(mp_cnt), 64'd1);
        chk("jal_br_cnt", 64'(br_cnt), 64'd2);

        // False hit on a non-branch
        drive(1'b1, 64'h40, 3'b000, 1'b0, 64'h0, 1'b1, 64'h80);
        step();
        chk("fh_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("fh_redirect_pc", redirect_pc, 64'h44);
        chk("fh_br_cnt", 64'(br_cnt), 64'd2);

        // Drain the three queued updates; the last one is the invalidation
        idle();
        wr_ready = 1'b1;
        step();
        step();
        chk("fh_head_type", 64'(wr_type), 64'd0);
        chk("fh_head_pc", wr_pc, 64'h40);
        step();
        chk("drained", 64'(wr_valid), 64'd0);

        // Shadow: back-to-back mispredicts, only the first counts
        br_before = m_br;
        drive(1'b1, 64'h100, 3'b001, 1'b1, 64'h200, 1'b0, 64'h104);
        step();
        drive(1'b1, 64'h200, 3'b011, 1'b1, 64'h900, 1'b0, 64'h204);
        step();
        chk("shadow_no_redirect", 64'(redirect_valid), 64'd0);
        chk("shadow_br_cnt", 64'(br_cnt), 64'(br_before + 1));
        idle();
        step();
        step();

        // Back-pressure: DEPTH+2 correct JALs with wr_ready low
        wr_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b1, 64'h5000 + 64'(16 * i), 3'b010, 1'b1, 64'h9000 + 64'(16 * i), 1'b0,
                  64'h9000 + 64'(16 * i));
            step();
        end
        idle();
        step();
        chk("bp_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("bp_head_stable", wr_pc, 64'h5000);
        wr_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("bp_drain_order", wr_pc, 64'h5000 + 64'(16 * i));
            step();
        end
        chk("bp_wr_valid_fall", 64'(wr_valid), 64'd0);

        // Full with simultaneous pop: push is accepted
        wr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 64'h7000 + 64'(16 * i), 3'b100, 1'b1, 64'hA000, 1'b0, 64'hA000);
            step();
        end
        wr_ready = 1'b1;
        drive(1'b1, 64'h7800, 3'b100, 1'b1, 64'hA000, 1'b0, 64'hA000);
        step();
        chk("full_pop_drop_cnt", 64'(drop_cnt), 64'd2);
        idle();
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin step(); guard++; end
        chk("full_pop_drained", 64'(guard < 20), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ty  = 3'($urandom_range(0, 6));
            pc  = 64'($urandom_range(0, 15)) << 2;
            tgt = 64'($urandom_range(0, 15)) << 4;
            tk  = (ty >= 3'b010) ? 1'b1 : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       pn = pc + 64'd4;
                1:       pn = tgt;
                default: pn = 64'($urandom_range(0, 255));
            endcase
            drive(1'($urandom_range(0, 3) != 0), pc, ty, tk, tgt, 1'($urandom_range(0, 1)), pn);
            wr_ready = 1'($urandom_range(0, 2) == 0);
            step();
        end

        // Reset with three queued entries and a live redirect
        idle();
        wr_ready = 1'b1;
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin step(); guard++; end
        step();
        wr_ready = 1'b0;
        drive(1'b1, 64'hB000, 3'b001, 1'b0, 64'hC000, 1'b0, 64'hB004);
        step();
        drive(1'b1, 64'hB100, 3'b010, 1'b1, 64'hC100, 1'b0, 64'hC100);
        step();
        drive(1'b1, 64'hB200, 3'b011, 1'b1, 64'hC200, 1'b0, 64'hB204);
        step();
        chk("pre_rst_redirect", 64'(redirect_valid), 64'd1);
        chk("pre_rst_wr_valid", 64'(wr_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("arst_redirect_pc", redirect_pc, 64'd0);
        chk("arst_wr_valid", 64'(wr_valid), 64'd0);
        chk("arst_wr_pc", wr_pc, 64'd0);
        chk("arst_wr_type", 64'(wr_type), 64'd0);
        chk("arst_wr_target", wr_target, 64'd0);
        chk("arst_wr_taken", 64'(wr_taken), 64'd0);
        chk("arst_br_cnt", 64'(br_cnt), 64'd0);
        chk("arst_mp_cnt", 64'(mp_cnt), 64'd0);
        chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        model_reset();
        idle();
        wr_ready = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_wr_valid", 64'(wr_valid), 64'd0);
        drive(1'b1, 64'hD000, 3'b010, 1'b1, 64'hE000, 1'b0, 64'hE000);
        wr_ready = 1'b0;
        step();
        chk("post_rst_new_update", 64'(wr_valid), 64'd1);
        chk("post_rst_new_pc", wr_pc, 64'hD000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
